// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: instruction opcodes, the default tag width and
// opcode classification helpers used by the write-back path.
package retire_stage_pkg;

  localparam int unsigned TagWDefault = 4;

  typedef enum logic [4:0] {
    NOTOKEN,
    ADD,
    SUB,
    SLT,
    LUI,
    JAL,
    JALR,
    BEQ,
    BNE,
    LB,
    LBU,
    LH,
    LHU,
    LW,
    SB,
    SH,
    SW
  } instruction_type;

  function automatic logic is_load(instruction_type op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic is_store(instruction_type op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/retire_stage_if.sv
// Execute-to-retire bundle plus the retire stage's outputs toward fetch, memory and the
// register bank. The instret signal exists only when RETIRE_INSTRET_EN is defined.
interface retire_stage_if
  import retire_stage_pkg::*;
#(
  parameter int unsigned TAG_W = TagWDefault
);
  // Execute-stage registered outputs
  logic [1:0][31:0]  result_in;
  logic              jump_in;
  logic [TAG_W-1:0]  tag_in;
  logic              we_in;
  logic              ls_operation_in;
  logic [3:0]        we_mem_in;
  instruction_type   i_in;
  logic [4:0]        regD_in;
  logic [31:0]       mem_data_in;

  // Retire-stage outputs
  logic              jump_out;
  logic [31:0]       new_pc;
  logic [TAG_W-1:0]  curr_tag;
  logic [31:0]       write_address;
  logic [31:0]       data_out;
  logic [3:0]        we_mem_out;
  logic              regbank_we;
  logic [4:0]        regbank_addr;
  logic [31:0]       regbank_data;
`ifdef RETIRE_INSTRET_EN
  logic [63:0]       instret;
`endif

  modport master (
    output result_in, jump_in, tag_in, we_in, ls_operation_in, we_mem_in, i_in, regD_in,
           mem_data_in,
    input  jump_out, new_pc, curr_tag, write_address, data_out, we_mem_out, regbank_we,
           regbank_addr, regbank_data
`ifdef RETIRE_INSTRET_EN
    , input instret
`endif
  );

  modport slave (
    input  result_in, jump_in, tag_in, we_in, ls_operation_in, we_mem_in, i_in, regD_in,
           mem_data_in,
    output jump_out, new_pc, curr_tag, write_address, data_out, we_mem_out, regbank_we,
           regbank_addr, regbank_data
`ifdef RETIRE_INSTRET_EN
    , output instret
`endif
  );

endinterface

// File: rtl/retire_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it. Purely combinational.
module retire_stage_load_align
  import retire_stage_pkg::*;
(
  input  logic [31:0]     i_mem_data,
  input  logic [1:0]      i_off,
  input  instruction_type i_op,
  output logic [31:0]     o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection; halfword ignores off[0]
  always_comb begin
    w_byte = 8'h00;
    unique case (i_off)
      2'd0: w_byte = i_mem_data[7:0];
      2'd1: w_byte = i_mem_data[15:8];
      2'd2: w_byte = i_mem_data[23:16];
      2'd3: w_byte = i_mem_data[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
  end

  // Extension by opcode; LW (and anything else) passes the word through
  always_comb begin
    o_data = i_mem_data;
    case (i_op)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h0, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0, w_half};
      default: o_data = i_mem_data;
    endcase
  end

endmodule

// File: rtl/retire_stage.sv
// Retire stage: commits instructions whose tag matches the current tag, writes the
// register bank one cycle later, issues memory writes and redirects fetch on taken jumps.
// Optional macro RETIRE_INSTRET_EN adds a 64-bit retired-instruction counter.
module retire_stage
  import retire_stage_pkg::*;
#(
  parameter int unsigned TAG_W    = TagWDefault,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  retire_stage_if.slave bus
);

  logic [TAG_W-1:0] r_curr_tag;
  logic             r_regbank_we;
  logic [4:0]       r_regbank_addr;
  logic [31:0]      r_regbank_data;
  logic             w_valid;
  logic             w_jump;
  logic [31:0]      w_load_data;

  retire_stage_load_align u_load_align (
    .i_mem_data (bus.mem_data_in),
    .i_off      (bus.result_in[1][1:0]),
    .i_op       (bus.i_in),
    .o_data     (w_load_data)
  );

  // Kill logic: stale tags never commit; everything is suppressed during reset
  always_comb begin
    w_valid = (bus.tag_in == r_curr_tag);
    w_jump  = ~reset & w_valid & bus.jump_in;
  end

  assign bus.jump_out      = w_jump;
  assign bus.new_pc        = reset ? RESET_PC : bus.result_in[1];
  assign bus.we_mem_out    = (~reset & w_valid) ? bus.we_mem_in : 4'h0;
  assign bus.write_address = bus.result_in[1];
  assign bus.data_out      = bus.result_in[0];
  assign bus.curr_tag      = r_curr_tag;
  assign bus.regbank_we    = r_regbank_we;
  assign bus.regbank_addr  = r_regbank_addr;
  assign bus.regbank_data  = r_regbank_data;

  // Current tag advances on every taken redirect, wrapping modulo 2^TAG_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_curr_tag <= '0;
    end else if (w_jump) begin
      r_curr_tag <= r_curr_tag + TAG_W'(1);
    end
  end

  // Registered write-back; stores and x0 never write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regbank_we   <= 1'b0;
      r_regbank_addr <= 5'd0;
      r_regbank_data <= 32'h0;
    end else begin
      r_regbank_we   <= w_valid & bus.we_in & (bus.regD_in != 5'd0) & ~is_store(bus.i_in);
      r_regbank_addr <= bus.regD_in;
      r_regbank_data <= is_load(bus.i_in) ? w_load_data : bus.result_in[0];
    end
  end

`ifdef RETIRE_INSTRET_EN
  logic [63:0] r_instret;

  // Count committed real instructions; bubbles (NOTOKEN) do not count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= 64'h0;
    end else if (w_valid && (bus.i_in != NOTOKEN)) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign bus.instret = r_instret;
`endif

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Fifth and last pipeline stage. Consumes the registered outputs of the execute stage.
- Decides which instructions commit by comparing their tag with the current tag register.
- Performs load-data byte/halfword alignment with sign or zero extension, then writes the register bank.
- Issues memory writes and redirects fetch on taken branches and jumps.

Parameters:
- TAG_W, 4, width of instruction tag and current-tag register.
- RESET_PC, 32'h0000_0000, value driven on new_pc while in reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- result_in[0]  in  32  primary result from execute: ALU/link value, or store data for stores
- result_in[1]  in  32  secondary result from execute: branch target, or memory address for loads/stores
- jump_in  in  1  branch/jump taken
- tag_in  in  TAG_W  instruction tag
- we_in  in  1  register-bank write request
- ls_operation_in  in  1  instruction is a load or store
- we_mem_in  in  4  byte-lane store strobes, already lane-aligned
- i_in  in  instruction_type  operation
- regD_in  in  5  destination register
- mem_data_in  in  32  memory read data, valid in the same cycle as the load instruction
- jump_out  out  1  redirect fetch (combinational)
- new_pc  out  32  redirect target
- curr_tag  out  TAG_W  current valid tag, fed back to fetch/decode
- write_address  out  32  memory write address
- data_out  out  32  memory write data
- we_mem_out  out  4  memory write strobes (combinational)
- regbank_we  out  1  register-bank write enable (registered)
- regbank_addr  out  5  register-bank write address (registered)
- regbank_data  out  32  register-bank write data (registered)

Behaviour:
- valid = (tag_in == curr_tag). Any instruction with valid=0 is killed: no register write, no memory write, no jump.
- Combinational outputs:
  - jump_out = valid & jump_in.
  - new_pc = result_in[1]; RESET_PC while in reset.
  - we_mem_out = valid ? we_mem_in : 0.
  - write_address = result_in[1]; data_out = result_in[0].
- curr_tag: reset to 0. At a clock edge with jump_out=1, curr_tag <= curr_tag+1 modulo 2^TAG_W (15 -> 0 for TAG_W=4).
- A jump and a register write in the same instruction (JAL/JALR) both take effect: the link value result_in[0] is written and fetch is redirected.
- Register write is registered, 1-cycle latency:
  - regbank_we <= valid & we_in & (regD_in != 0).
  - regbank_addr <= regD_in.
  - regbank_data <= loaded value if i_in is a load, else result_in[0].
- Load alignment uses off = result_in[1][1:0]:
  - LB/LBU: select byte off, then sign- or zero-extend.
  - LH/LHU: select halfword off[1], then sign- or zero-extend; off[0] is ignored.
  - LW: whole word; off is ignored.
- Stores never assert regbank_we, whatever we_in says.
- Reset, including mid-operation: regbank_we=0, regbank_addr=0, regbank_data=0, curr_tag=0, jump_out=0, we_mem_out=0. The instruction present during reset is discarded.
- When reset deasserts, an in-flight instruction with tag 0 commits normally.

Optional Feature:
- Macro RETIRE_INSTRET_EN.
- When defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 at every edge where valid=1 and i_in != NOTOKEN.
  - Wraps at 2^64.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package my_pkg (existing): instruction_type, including LB/LBU/LH/LHU/LW/SB/SH/SW/NOTOKEN; TAG_W default constant.
- Sub-module load_align: inputs mem_data_in, off, i_in; output the aligned and extended 32-bit value. Purely combinational.
- The retire_stage top holds curr_tag, the registered write-back path and the kill logic.

Test Plan:
- ADD, tag 0, regD=5, result_in[0]=32'h1234 -> next cycle regbank_we=1, addr=5, data=32'h1234.
- LB at address 0x103 with mem_data_in=32'h80AA_BBCC -> data=32'hFFFF_FF80. Same with LBU -> 32'h0000_0080. LH at 0x102 -> 32'hFFFF_80AA.
- JAL, tag 0, jump_in=1, result_in[1]=0x400, result_in[0]=0x104, regD=1 -> jump_out=1 and new_pc=0x400 same cycle; curr_tag=1 after the edge; x1 written with 0x104. Following instruction with tag 0 is killed: no write, no jump.
- SW, we_mem_in=4'hF, address 0x200, data 0xDEAD_BEEF -> we_mem_out=4'hF same cycle, regbank_we stays 0. Same store with stale tag -> we_mem_out=0.
- 16 consecutive taken jumps -> curr_tag steps 0..15 and wraps to 0. Reset asserted mid-sequence -> curr_tag=0 and all strobes 0 on the next edge.
- Write with regD=0 -> regbank_we=0. With RETIRE_INSTRET_EN: 10 valid instructions plus 3 killed ones -> instret=10.
